// File: rtl/uart_pkt_loader_if.sv
// Byte streams from/to the UART engines plus the ROM word-write port
// driven by the debug download loader.
interface uart_pkt_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_pkt_loader.sv
// UART debug download endpoint: reassembles seq/data/CRC packets,
// validates them and streams payload words into instruction ROM.
module uart_pkt_loader #(
    parameter int unsigned    PKT_DATA_SIZE   = 128,
    parameter int unsigned    FILE_SIZE_INDEX = 60,
    parameter int unsigned    ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] ROM_BASE     = '0,
    parameter int unsigned    TIMEOUT_CYCLES  = 50000,
    parameter logic [7:0]     ACK_BYTE        = 8'h06,
    parameter logic [7:0]     NAK_BYTE        = 8'h15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                debug_en,
    uart_pkt_loader_if.master   bus,
    output logic [31:0]         file_size,
    output logic                busy,
    output logic                done
);
    localparam int BW = $clog2(PKT_DATA_SIZE);
    localparam int WW = BW - 2;
    localparam int CW = $clog2(PKT_DATA_SIZE + 3);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DLAST = CW'(PKT_DATA_SIZE);
    localparam logic [CW-1:0] LAST  = CW'(PKT_DATA_SIZE + 2);
    localparam logic [31:0]   MAX_SIZE = 32'(255 * PKT_DATA_SIZE);

    typedef enum logic [2:0] {
        IDLE, RECV, CHECK, WRITE, REPLY, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     buf_q [PKT_DATA_SIZE];
    logic [CW-1:0]  cnt_q;
    logic [7:0]     seq_q, exp_q, crc_lo_q, crc_hi_q;
    logic [15:0]    crc_q;
    logic [TW-1:0]  idle_q;
    logic [31:0]    fsize_q, off_q;
    logic [WW-1:0]  w_q;
    logic           ack_q, inc_q, fin_q, done_q;

    logic [31:0]    size_dec, pkt_off, word_off, next_off;
    logic [BW-1:0]  wr_idx;
    logic           size_ok, crc_bad, dup, w_last, hs, tx_v, we;
    logic           ck_ack, ck_new, ck_wr, ck_p0, ck_fin;

    function automatic logic [15:0] crc_step(
        input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign size_dec = {buf_q[FILE_SIZE_INDEX],     buf_q[FILE_SIZE_INDEX + 1],
                       buf_q[FILE_SIZE_INDEX + 2], buf_q[FILE_SIZE_INDEX + 3]};
    assign size_ok  = (size_dec != 32'd0) && (size_dec <= MAX_SIZE);
    assign crc_bad  = {crc_hi_q, crc_lo_q} != crc_q;
    assign dup      = (exp_q != 8'd0) && (seq_q == exp_q - 8'd1);
    assign pkt_off  = (32'(seq_q) - 32'd1) * PKT_DATA_SIZE;
    assign word_off = off_q + 32'({w_q, 2'b00});
    assign next_off = word_off + 32'd4;
    assign w_last   = (w_q == '1) || (next_off >= fsize_q);
    assign wr_idx   = BW'(cnt_q - CW'(1));
    assign tx_v     = (state_q == REPLY);
    assign we       = (state_q == WRITE);
    assign hs       = tx_v && bus.tx_ready;

    always_comb begin
        state_d = state_q;
        ck_ack  = 1'b0;
        ck_new  = 1'b0;
        ck_wr   = 1'b0;
        ck_p0   = 1'b0;
        ck_fin  = (pkt_off + PKT_DATA_SIZE) >= fsize_q;
        unique case (state_q)
            IDLE:  if (bus.rx_valid) state_d = RECV;
            RECV: begin
                if (bus.rx_valid) begin
                    if (cnt_q == LAST) state_d = CHECK;
                end else if (idle_q == TW'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                // Checks overlap, so order encodes priority
                if (crc_bad) begin
                    ck_ack = 1'b0;
                end else if (dup) begin
                    ck_ack = 1'b1;
                end else if (seq_q != exp_q) begin
                    ck_ack = 1'b0;
                end else if (exp_q == 8'd0) begin
                    ck_ack = size_ok;
                    ck_new = size_ok;
                    ck_p0  = size_ok;
                end else if (pkt_off < fsize_q) begin
                    ck_wr  = 1'b1;
                    ck_new = 1'b1;
                end else begin
                    ck_ack = 1'b1;
                    ck_new = 1'b1;
                end
                state_d = ck_wr ? WRITE : REPLY;
            end
            WRITE: if (w_last) state_d = REPLY;
            REPLY: if (hs) state_d = (ack_q && fin_q) ? DONE : IDLE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (!debug_en) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (state_q == RECV && bus.rx_valid && cnt_q <= DLAST)
            buf_q[wr_idx] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            seq_q    <= '0;
            exp_q    <= '0;
            crc_q    <= 16'hFFFF;
            crc_lo_q <= '0;
            crc_hi_q <= '0;
            idle_q   <= '0;
            fsize_q  <= '0;
            off_q    <= '0;
            w_q      <= '0;
            ack_q    <= 1'b0;
            inc_q    <= 1'b0;
            fin_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && debug_en && bus.rx_valid) begin
                seq_q  <= bus.rx_data;
                cnt_q  <= CW'(1);
                crc_q  <= 16'hFFFF;
                idle_q <= '0;
            end
            if (state_q == RECV) begin
                if (bus.rx_valid) begin
                    cnt_q  <= cnt_q + CW'(1);
                    idle_q <= '0;
                    if (cnt_q <= DLAST)
                        crc_q <= crc_step(crc_q, bus.rx_data);
                    if (cnt_q == DLAST + CW'(1)) crc_lo_q <= bus.rx_data;
                    if (cnt_q == LAST)           crc_hi_q <= bus.rx_data;
                end else begin
                    idle_q <= idle_q + TW'(1);
                end
            end
            if (state_q == CHECK) begin
                ack_q <= ck_ack | ck_wr;
                inc_q <= ck_new;
                fin_q <= ck_fin && !ck_p0;
                off_q <= pkt_off;
                w_q   <= '0;
                if (ck_p0) fsize_q <= size_dec;
            end
            if (we) w_q <= w_q + WW'(1);
            if (hs && ack_q) begin
                if (inc_q) exp_q  <= exp_q + 8'd1;
                if (fin_q) done_q <= 1'b1;
            end
            if (!debug_en) begin
                exp_q   <= '0;
                fsize_q <= '0;
                done_q  <= 1'b0;
            end
        end
    end

    assign bus.tx_valid  = tx_v;
    assign bus.tx_data   = tx_v ? (ack_q ? ACK_BYTE : NAK_BYTE) : 8'h00;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = we ? ROM_BASE + ADDR_W'(word_off) : '0;
    assign bus.mem_wdata = we ? {buf_q[{w_q, 2'b11}], buf_q[{w_q, 2'b10}],
                                 buf_q[{w_q, 2'b01}], buf_q[{w_q, 2'b00}]}
                              : 32'h0;
    assign file_size = fsize_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = done_q;
endmodule

// File: tb/tb_uart_pkt_loader.sv
// Directed bench for uart_pkt_loader: framing, CRC, sequencing,
// timeout, reply handshake and debug_en abort.
module tb_uart_pkt_loader;
    localparam int PKT = 128;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        debug_en = 1'b0;
    logic [31:0] file_size;
    logic        busy, done;

    always #5 clk = ~clk;

    uart_pkt_loader_if #(.ADDR_W(32)) ifc ();

    uart_pkt_loader dut (
        .clk(clk),
        .rst(rst),
        .debug_en(debug_en),
        .bus(ifc),
        .file_size(file_size),
        .busy(busy),
        .done(done)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          nwe = 0;
    int          nrep = 0;
    int          nw0, nr0, k;
    bit          got;
    logic        we_s, tx_s, hs_s;
    logic [7:0]  txd_s, last_tx;
    logic [31:0] addr_s;
    logic [15:0] cref;
    logic [31:0] rom_m [0:127];
    logic [7:0]  pkt [0:130];
    string       ref_s;

    task automatic chk(input string tag, input logic [31:0] got_v,
                       input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                            input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] src(input int i);
        return 8'((i * 37 + 11) ^ (i >> 5));
    endfunction

    task automatic set_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 1; i <= PKT; i++) c = crc_upd(c, pkt[i]);
        pkt[129] = c[7:0];
        pkt[130] = c[15:8];
    endtask

    task automatic build_data(input logic [7:0] seq, input int n);
        pkt[0] = seq;
        for (int i = 0; i < PKT; i++) pkt[i + 1] = src((n - 1) * PKT + i);
        set_crc();
    endtask

    task automatic build_p0(input logic [31:0] size);
        pkt[0] = 8'h00;
        for (int i = 1; i <= PKT; i++) pkt[i] = 8'h00;
        pkt[61] = size[31:24];
        pkt[62] = size[23:16];
        pkt[63] = size[15:8];
        pkt[64] = size[7:0];
        set_crc();
    endtask

    // Sample on the falling edge, then return just after the rising edge
    task automatic tick();
        @(negedge clk);
        we_s   = ifc.mem_we;
        tx_s   = ifc.tx_valid;
        txd_s  = ifc.tx_data;
        addr_s = ifc.mem_addr;
        hs_s   = ifc.tx_valid && ifc.tx_ready;
        if (we_s) begin
            nwe++;
            rom_m[addr_s[8:2]] = ifc.mem_wdata;
        end
        if (hs_s) begin
            nrep++;
            last_tx = txd_s;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = pkt[i];
            tick();
        end
        ifc.rx_valid = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] exp_b,
                        input int exp_nw, input logic [31:0] a0);
        int w0, r0, fwe, ftx;
        logic [31:0] af, al;
        bit hit;
        w0 = nwe; r0 = nrep; fwe = -1; ftx = -1;
        af = '0; al = '0; hit = 1'b0;
        send(131);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (we_s) begin
                if (fwe < 0) begin fwe = i; af = addr_s; end
                al = addr_s;
            end
            if (tx_s && ftx < 0) ftx = i;
            if (hs_s) begin hit = 1'b1; break; end
        end
        chk({tag, "_hs"}, 32'(hit), 32'd1);
        chk({tag, "_byte"}, 32'(last_tx), 32'(exp_b));
        chk({tag, "_nrep"}, nrep - r0, 1);
        chk({tag, "_nwe"}, nwe - w0, exp_nw);
        chk({tag, "_txlat"}, ftx, exp_nw + 2);
        if (exp_nw > 0) begin
            chk({tag, "_welat"}, fwe, 2);
            chk({tag, "_a0"}, af, a0);
            chk({tag, "_alast"}, al, a0 + 32'(4 * (exp_nw - 1)));
        end
        tick();
        chk({tag, "_txdrop"}, 32'(tx_s), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;
        ifc.tx_ready = 1'b1;
        repeat (3) tick();
        chk("rst_txv", 32'(tx_s), 32'd0);
        chk("rst_we", 32'(we_s), 32'd0);
        chk("rst_addr", addr_s, 32'd0);
        chk("rst_txd", 32'(txd_s), 32'd0);
        chk("rst_fsize", file_size, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        debug_en = 1'b1;
        tick();

        ref_s = "123456789";
        cref = 16'hFFFF;
        for (int i = 0; i < 9; i++) cref = crc_upd(cref, ref_s[i]);
        chk("crc_model", 32'(cref), 32'h4B37);

        build_data(8'd2, 2);
        xfer("seq_ahead0", NAK, 0, 0);
        build_p0(32'h0001_0000);
        xfer("big_size", NAK, 0, 0);
        chk("big_fsize", file_size, 32'd0);
        build_p0(32'h0);
        xfer("zero_size", NAK, 0, 0);

        build_p0(32'h0000_0104);
        nr0 = nrep;
        send(50);
        chk("to_busy", 32'(busy), 32'd1);
        repeat (50001) tick();
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_norep", nrep - nr0, 0);
        xfer("p0", ACK, 0, 0);
        chk("p0_fsize", file_size, 32'd260);

        build_data(8'd1, 1);
        pkt[130] = pkt[130] ^ 8'h01;
        xfer("bad_crc", NAK, 0, 0);

        build_data(8'd2, 2);
        ifc.tx_ready = 1'b0;
        send(131);
        got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (tx_s) begin got = 1'b1; break; end
        end
        chk("hold_seen", 32'(got), 32'd1);
        repeat (10) begin
            tick();
            chk("hold_txv", 32'(tx_s), 32'd1);
            chk("hold_txd", 32'(txd_s), 32'(NAK));
        end
        ifc.tx_ready = 1'b1;
        tick();
        chk("hold_hs", 32'(hs_s), 32'd1);
        chk("hold_byte", 32'(last_tx), 32'(NAK));
        tick();
        chk("hold_drop", 32'(tx_s), 32'd0);

        build_data(8'd1, 1);
        xfer("p1", ACK, 32, 32'h000);
        xfer("p1_dup", ACK, 0, 0);
        build_data(8'd2, 2);
        xfer("p2", ACK, 32, 32'h080);
        chk("p2_done", 32'(done), 32'd0);
        build_data(8'd3, 3);
        xfer("p3", ACK, 1, 32'h100);
        chk("p3_done", 32'(done), 32'd1);
        chk("p3_busy", 32'(busy), 32'd0);

        for (int w = 0; w < 65; w++)
            chk($sformatf("rom_%0d", w), rom_m[w],
                {src(4 * w + 3), src(4 * w + 2), src(4 * w + 1), src(4 * w)});

        nw0 = nwe; nr0 = nrep;
        build_data(8'd4, 4);
        send(131);
        repeat (10) tick();
        chk("done_norep", nrep - nr0, 0);
        chk("done_nowe", nwe - nw0, 0);
        chk("done_hold", 32'(done), 32'd1);

        debug_en = 1'b0;
        tick();
        chk("off_done", 32'(done), 32'd0);
        chk("off_fsize", file_size, 32'd0);
        chk("off_busy", 32'(busy), 32'd0);
        debug_en = 1'b1;
        tick();

        build_p0(32'h0000_0104);
        xfer("p0_again", ACK, 0, 0);

        build_data(8'd1, 1);
        nw0 = nwe; nr0 = nrep;
        send(131);
        k = 0; got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (we_s) k++;
            if (k == 4) begin got = 1'b1; break; end
        end
        chk("abort_reach", 32'(got), 32'd1);
        debug_en = 1'b0;
        tick();
        chk("abort_we5", 32'(we_s), 32'd1);
        tick();
        chk("abort_we", 32'(we_s), 32'd0);
        chk("abort_txv", 32'(tx_s), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fsize", file_size, 32'd0);
        repeat (20) tick();
        chk("abort_nwe", nwe - nw0, 5);
        chk("abort_norep", nrep - nr0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
